// File: rtl/filter_out_422_pack.sv
// filter_out_422_pack: YUV444 -> YUV422 output stage.
// Pairs adjacent pixels, averages chroma with rounding, holds the newest
// pair back one slot so end-of-line can be tagged, queues pairs in a small
// FIFO and serialises each pair as two {C,Y} beats on a valid/ready port.
module filter_out_422_pack #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_vs,
    input  logic                      i_de,
    input  logic [DATA_WIDTH-1:0]     i_y,
    input  logic [DATA_WIDTH-1:0]     i_u,
    input  logic [DATA_WIDTH-1:0]     i_v,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [2*DATA_WIDTH-1:0]   o_data,
    output logic                      o_sof,
    output logic                      o_eol,
    output logic                      o_overflow,
    output logic [FIFO_AW:0]          o_level
);

    typedef enum logic {S_EVEN, S_ODD} state_t;

    typedef struct packed {
        logic                  sof;
        logic                  eol;
        logic [DATA_WIDTH-1:0] cr;
        logic [DATA_WIDTH-1:0] cb;
        logic [DATA_WIDTH-1:0] y1;
        logic [DATA_WIDTH-1:0] y0;
    } entry_t;

    // Rounded mean of two components; the extra sum bit keeps it from wrapping.
    function automatic logic [DATA_WIDTH-1:0] avg_round(input logic [DATA_WIDTH-1:0] a,
                                                        input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b} + (DATA_WIDTH+1)'(1);
        return s[DATA_WIDTH:1];
    endfunction

    state_t                 state;
    logic                   de_d, vs_d, sof_arm;
    logic [DATA_WIDTH-1:0]  y_p0, u_p0, v_p0;
    logic                   vld_p1, final_p1;
    logic [DATA_WIDTH-1:0]  y0_p1, y1_p1, cb_p1, cr_p1;

    entry_t                 mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]     wr_ptr, rd_ptr;
    logic [FIFO_AW:0]       count;
    logic                   beat_sel;

    logic   de_fall, vs_rise, form_pair;
    logic   push_req, push_eol, full, pop, wr_en, drop;
    entry_t push_entry, head;

    assign de_fall   = de_d & ~i_de;
    assign vs_rise   = i_vs & ~vs_d;
    assign form_pair = (state == S_ODD) && (i_de || de_fall);

    assign full    = (count == (FIFO_AW+1)'(FIFO_DEPTH));
    assign o_valid = (count != '0);
    assign o_level = count;
    assign pop     = o_valid & i_ready & beat_sel;
    assign wr_en   = push_req & (~full | pop);
    assign drop    = push_req & full & ~pop;
    assign head    = mem[rd_ptr];

    // Decide whether the pending pair leaves this cycle and with which flags.
    always_comb begin
        push_req = 1'b0;
        push_eol = 1'b0;
        if (vld_p1 && final_p1) begin
            push_req = 1'b1;
            push_eol = 1'b1;
        end else if (form_pair && vld_p1) begin
            push_req = 1'b1;
        end else if (de_fall && state == S_EVEN && vld_p1) begin
            push_req = 1'b1;
            push_eol = 1'b1;
        end
        push_entry = '{sof: sof_arm, eol: push_eol, cr: cr_p1, cb: cb_p1, y1: y1_p1, y0: y0_p1};
    end

    // Control: edge detect, pair FSM, pending-slot valid, SOF arming, sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            de_d       <= 1'b0;
            vs_d       <= 1'b0;
            state      <= S_EVEN;
            vld_p1     <= 1'b0;
            final_p1   <= 1'b0;
            sof_arm    <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            de_d <= i_de;
            vs_d <= i_vs;
            if (state == S_EVEN && i_de)
                state <= S_ODD;
            else if (form_pair)
                state <= S_EVEN;
            if (form_pair) begin
                vld_p1   <= 1'b1;
                final_p1 <= ~i_de;
            end else if (push_req && push_eol) begin
                vld_p1   <= 1'b0;
                final_p1 <= 1'b0;
            end
            if (vs_rise)
                sof_arm <= 1'b1;
            else if (push_req)
                sof_arm <= 1'b0;
            if (drop)
                o_overflow <= 1'b1;
            else if (vs_rise)
                o_overflow <= 1'b0;
        end
    end

    // Datapath: even-pixel latch (p0) and pending pair contents (p1).
    always_ff @(posedge clk) begin
        if (state == S_EVEN && i_de) begin
            y_p0 <= i_y;
            u_p0 <= i_u;
            v_p0 <= i_v;
        end
        if (form_pair) begin
            y0_p1 <= y_p0;
            if (i_de) begin
                y1_p1 <= i_y;
                cb_p1 <= avg_round(u_p0, i_u);
                cr_p1 <= avg_round(v_p0, i_v);
            end else begin
                y1_p1 <= y_p0;
                cb_p1 <= u_p0;
                cr_p1 <= v_p0;
            end
        end
    end

    // FIFO pointers, occupancy and beat selector.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            beat_sel <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (o_valid && i_ready)
                beat_sel <= ~beat_sel;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= push_entry;
    end

    // Beat serializer: Cb half then Cr half of the head entry, zero when idle.
    always_comb begin
        o_data = '0;
        o_sof  = 1'b0;
        o_eol  = 1'b0;
        if (o_valid) begin
            if (!beat_sel) begin
                o_data = {head.cb, head.y0};
                o_sof  = head.sof;
            end else begin
                o_data = {head.cr, head.y1};
                o_eol  = head.eol;
            end
        end
    end

endmodule
